// File: rtl/dmem_dma_pkg.sv
// Shared types and constants for the data-memory word-copy DMA engine.
package dma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StRead,
    StWrite,
    StDone
  } dma_state_t;

  localparam logic [31:0] SWITCH_ADDR = 32'hC000_0000;
  localparam logic [31:0] LED_ADDR    = 32'hC000_0004;
  localparam int unsigned WORD_BYTES  = 4;

endpackage

// File: rtl/dmem_dma_if.sv
// Single-cycle data-memory bus shared by the CPU and the DMA initiator.
interface dmem_dma_if;
  logic        bus_req;
  logic        bus_gnt;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  modport master (
    output bus_req, mem_a, mem_wd, mem_we,
    input  bus_gnt, mem_rd
  );

  modport slave (
    input  bus_req, mem_a, mem_wd, mem_we,
    output bus_gnt, mem_rd
  );
endinterface

// File: rtl/dmem_dma_addr_gen.sv
// Word-index counter with source/destination address and last-word generation.
module dma_addr_gen
  import dma_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  output logic [31:0]      src_addr,
  output logic [31:0]      dst_addr,
  output logic             last
);

  logic [LEN_W-1:0] idx_q;
  logic [31:0]      offset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
    end else if (clr) begin
      idx_q <= '0;
    end else if (inc) begin
      idx_q <= idx_q + LEN_W'(1);
    end
  end

  // Modulo-2^32 arithmetic; wrap-around is intentionally not detected.
  assign offset   = 32'(idx_q) * 32'(WORD_BYTES);
  assign src_addr = src + offset;
  assign dst_addr = dst + offset;
  assign last     = (idx_q == len - LEN_W'(1));

endmodule

// File: rtl/dmem_dma.sv
// Word-copy DMA engine: arbitrates for the data-memory bus and copies len words src -> dst.
module dmem_dma
  import dma_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  dmem_dma_if.master       bus
);

  dma_state_t       state_q;
  logic [31:0]      src_q, dst_q, data_q;
  logic [LEN_W-1:0] len_q;
  logic             busy_q, done_q, err_q, req_q;
  logic [31:0]      src_addr, dst_addr;
  logic             last, misaligned;

  assign misaligned = (|src[1:0]) | (|dst[1:0]);

  dma_addr_gen #(
    .LEN_W (LEN_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .clr      (state_q == StIdle),
    .inc      ((state_q == StWrite) && bus.bus_gnt),
    .src      (src_q),
    .dst      (dst_q),
    .len      (len_q),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .last     (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            src_q  <= src;
            dst_q  <= dst;
            len_q  <= len;
            busy_q <= 1'b1;
            if (misaligned) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (len == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StReq;
              req_q   <= 1'b1;
            end
          end
        end
        StReq: begin
          if (bus.bus_gnt) state_q <= StRead;
        end
        StRead: begin
          if (bus.bus_gnt) begin
            data_q  <= bus.mem_rd;
            state_q <= StWrite;
          end
        end
        StWrite: begin
          if (bus.bus_gnt) begin
            if (last) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              req_q   <= 1'b0;
            end else begin
              state_q <= StRead;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Write strobe follows the live grant so a dropped grant suppresses the write at once.
  always_comb begin
    bus.mem_a  = '0;
    bus.mem_wd = '0;
    bus.mem_we = 1'b0;
    if (state_q == StRead) begin
      bus.mem_a = src_addr;
    end else if (state_q == StWrite) begin
      bus.mem_a  = dst_addr;
      bus.mem_wd = data_q;
      bus.mem_we = bus.bus_gnt;
    end
  end

  assign bus.bus_req = req_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
